// File: rtl/riscv_mem_unit_pkg.sv
// rtl/riscv_mem_unit_pkg.sv - shared funct3 codes, port FSM states and access-legality helper
// Purpose: common definitions for riscv_mem_unit and its port sequencer.
//   F3_*          RV32I load/store size/sign codes
//   port_state_t  IDLE/WAIT/RESP encoding of the per-port sequencer
//   f3_legal()    1 when funct3 is a defined load (we=0) or store (we=1) code
package riscv_mem_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } port_state_t;

  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    if (we) return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/riscv_mem_port_seq.sv
// rtl/riscv_mem_port_seq.sv - IDLE/WAIT/RESP request sequencer with wait-state counter
// Purpose: paces one memory port; one access per WAIT_STATES+2 cycles.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   req       access request, only looked at in IDLE
//   capture   IDLE and req: parent latches the request on this edge
//   resp      one-cycle response strobe (state RESP)
module riscv_mem_port_seq
  import riscv_mem_unit_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  output logic capture,
  output logic resp
);

  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  port_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      // Counter reaching zero marks the last wait cycle.
      ST_WAIT: begin
        if (cnt == 4'd0) state_nxt = ST_RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    capture = (state == ST_IDLE) && req;
    resp    = (state == ST_RESP);
  end

endmodule

// File: rtl/riscv_mem_unit_ram.sv
// rtl/riscv_mem_unit_ram.sv - data RAM array, asynchronous read, synchronous word write
// Purpose: word-wide RAM; byte merging is done by the caller. Contents are not reset.
// Ports:
//   clk    clock
//   we     write full word wdata at addr on the rising edge
//   addr   word index (shared read/write)
//   wdata  word to write
//   rdata  word at addr
module riscv_mem_unit_ram #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/riscv_mem_unit_rom.sv
// rtl/riscv_mem_unit_rom.sv - instruction ROM array, asynchronous read
// Purpose: word-wide ROM; contents are loaded from outside (mem[]), never reset.
// Ports:
//   addr   word index
//   rdata  word at addr
module riscv_mem_unit_rom #(
  parameter int WORDS = 1024,
  localparam int AW = $clog2(WORDS)
) (
  input  logic [AW-1:0] addr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  assign rdata = mem[addr];

endmodule

// File: rtl/riscv_mem_unit.sv
// rtl/riscv_mem_unit.sv - Harvard memory unit: ROM fetch port, RAM/GPIO data port
// Purpose: valid/ready memory for the multi-cycle core with wait states, byte/half/word
//   access, load extension, and fault reporting.
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   i_req, i_addr                   fetch request and byte address
//   i_rdata, i_ready, i_fault       fetched word, completion pulse, fetch fault
//   d_req, d_we, d_funct3           data request, store flag, RV32I size/sign code
//   d_addr, d_wdata                 byte address, right-aligned store data
//   d_rdata, d_ready, d_fault       load result, completion pulse, data fault
//   gpio                            memory-mapped output register
module riscv_mem_unit
  import riscv_mem_unit_pkg::*;
#(
  parameter int          ROM_WORDS   = 1024,
  parameter int          RAM_WORDS   = 1024,
  parameter int          GPIO_WIDTH  = 8,
  parameter logic [31:0] GPIO_ADDR   = 32'hFFFF_FF00,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [31:0]           i_addr,
  output logic [31:0]           i_rdata,
  output logic                  i_ready,
  output logic                  i_fault,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [2:0]            d_funct3,
  input  logic [31:0]           d_addr,
  input  logic [31:0]           d_wdata,
  output logic [31:0]           d_rdata,
  output logic                  d_ready,
  output logic                  d_fault,
  output logic [GPIO_WIDTH-1:0] gpio
);

  localparam int          ROM_AW    = $clog2(ROM_WORDS);
  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [29:0] GPIO_WORD = GPIO_ADDR[31:2];

  logic i_cap, i_resp, d_cap, d_resp;

  riscv_mem_port_seq #(.WAIT_STATES(WAIT_STATES)) i_seq (
    .clk(clk), .rst(rst), .req(i_req), .capture(i_cap), .resp(i_resp)
  );

  riscv_mem_port_seq #(.WAIT_STATES(WAIT_STATES)) d_seq (
    .clk(clk), .rst(rst), .req(d_req), .capture(d_cap), .resp(d_resp)
  );

  // Request capture; held stable until the next IDLE sample.
  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic        d_we_q;
  logic [2:0]  d_funct3_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_addr_q   <= 32'd0;
      d_addr_q   <= 32'd0;
      d_wdata_q  <= 32'd0;
      d_we_q     <= 1'b0;
      d_funct3_q <= 3'd0;
    end else begin
      if (i_cap) i_addr_q <= i_addr;
      if (d_cap) begin
        d_addr_q   <= d_addr;
        d_wdata_q  <= d_wdata;
        d_we_q     <= d_we;
        d_funct3_q <= d_funct3;
      end
    end
  end

  // Fetch port
  logic [31:0] rom_rdata;
  logic        i_bad;

  riscv_mem_unit_rom #(.WORDS(ROM_WORDS)) rom (
    .addr(i_addr_q[ROM_AW+1:2]), .rdata(rom_rdata)
  );

  assign i_bad   = (i_addr_q[1:0] != 2'b00) || (i_addr_q[31:ROM_AW+2] != '0);
  assign i_ready = i_resp;
  assign i_fault = i_resp && i_bad;
  assign i_rdata = (i_resp && !i_bad) ? rom_rdata : 32'd0;

  // Data port decode
  logic [1:0]            lane, dsize;
  logic                  is_gpio, is_ram, misalign, d_bad, store_ok;
  logic [31:0]           ram_rdata, old_word, shifted, wdata_sh, merged, load_val;
  logic [3:0]            be;
  logic [GPIO_WIDTH-1:0] gpio_q;

  assign lane     = d_addr_q[1:0];
  assign dsize    = d_funct3_q[1:0];
  // GPIO decode wins, so a GPIO_ADDR inside RAM range shadows that RAM word.
  assign is_gpio  = (d_addr_q[31:2] == GPIO_WORD);
  assign is_ram   = !is_gpio && (d_addr_q[31:RAM_AW+2] == '0);
  assign misalign = ((dsize == 2'd1) && lane[0]) || ((dsize == 2'd2) && (lane != 2'b00));
  assign d_bad    = !f3_legal(d_we_q, d_funct3_q) || misalign || !(is_gpio || is_ram);
  assign store_ok = d_resp && d_we_q && !d_bad;

  riscv_mem_unit_ram #(.WORDS(RAM_WORDS)) ram (
    .clk(clk), .we(store_ok && is_ram), .addr(d_addr_q[RAM_AW+1:2]),
    .wdata(merged), .rdata(ram_rdata)
  );

  assign old_word = is_gpio ? 32'(gpio_q) : ram_rdata;
  assign shifted  = old_word >> {lane, 3'b000};
  assign wdata_sh = d_wdata_q << {lane, 3'b000};

  always_comb begin
    load_val = shifted;
    be       = 4'b1111;
    case (dsize)
      2'd0: begin
        load_val = d_funct3_q[2] ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        be       = 4'b0001 << lane;
      end
      2'd1: begin
        load_val = d_funct3_q[2] ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        be       = 4'b0011 << lane;
      end
      default: begin
        load_val = shifted;
        be       = 4'b1111;
      end
    endcase
  end

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata_sh[8*i +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     gpio_q <= '0;
    else if (store_ok && is_gpio) gpio_q <= merged[GPIO_WIDTH-1:0];
  end

  assign gpio    = gpio_q;
  assign d_ready = d_resp;
  assign d_fault = d_resp && d_bad;
  assign d_rdata = (d_resp && !d_we_q && !d_bad) ? load_val : 32'd0;

endmodule

// File: tb/tb_riscv_mem_unit.sv
// tb/tb_riscv_mem_unit.sv - scoreboard bench for riscv_mem_unit at WAIT_STATES 0 and 3
module tb_riscv_mem_unit;
  import riscv_mem_unit_pkg::*;

  localparam logic [31:0] GPIO_A = 32'hFFFF_FF00;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_req[2], i_ready[2], i_fault[2];
  logic [31:0] i_addr[2], i_rdata[2];
  logic        d_req[2], d_we[2], d_ready[2], d_fault[2];
  logic [2:0]  d_funct3[2];
  logic [31:0] d_addr[2], d_wdata[2], d_rdata[2];
  logic [7:0]  gpio[2];

  riscv_mem_unit #(.WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_ready(i_ready[0]), .i_fault(i_fault[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_funct3(d_funct3[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_rdata(d_rdata[0]), .d_ready(d_ready[0]), .d_fault(d_fault[0]), .gpio(gpio[0])
  );

  riscv_mem_unit #(.WAIT_STATES(3)) dut3 (
    .clk(clk), .rst(rst),
    .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_ready(i_ready[1]), .i_fault(i_fault[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_funct3(d_funct3[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_rdata(d_rdata[1]), .d_ready(d_ready[1]), .d_fault(d_fault[1]), .gpio(gpio[1])
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rom_m [1024];
  logic [31:0] ram_m [2][1024];
  logic [7:0]  gpio_m [2];
  exp_t        iq [2][$];
  exp_t        dq [2][$];
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference behaviour, expressed in bytes and addresses.
  function automatic void model_fetch(input logic [31:0] a, output logic [31:0] rd, output logic f);
    if ((a % 4 != 0) || (a / 4 >= 1024)) begin rd = 0; f = 1; end
    else begin rd = rom_m[a / 4]; f = 0; end
  endfunction

  function automatic void model_data(input int k, input logic we, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] wd,
                                     output logic [31:0] rd, output logic f);
    int n, off;
    logic legal, to_gpio;
    logic [31:0] word, val;
    n     = (f3[1:0] == 0) ? 1 : (f3[1:0] == 1) ? 2 : 4;
    legal = we ? (f3 <= 2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    rd = 0; f = 0;
    if (!legal || (a % n != 0)) begin f = 1; return; end
    to_gpio = (a / 4 == GPIO_A / 4);
    if (to_gpio)         word = 32'(gpio_m[k]);
    else if (a < 4096)   word = ram_m[k][a / 4];
    else begin f = 1; return; end
    off = int'(a % 4);
    if (we) begin
      for (int i = 0; i < n; i++) word[8*(off+i) +: 8] = wd[8*i +: 8];
      if (to_gpio) gpio_m[k] = word[7:0];
      else         ram_m[k][a / 4] = word;
    end else begin
      val = 0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = word[8*(off+i) +: 8];
      if (n < 4 && !f3[2] && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      rd = val;
    end
  endfunction

  function automatic logic [31:0] ram_peek(input int k, input int idx);
    return (k == 0) ? dut0.ram.mem[idx] : dut3.ram.mem[idx];
  endfunction

  // Monitor: pops the scoreboard whenever a port reports ready.
  exp_t me;
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (i_ready[k]) begin
        if (iq[k].size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL i_ready_unexpected[%0d]: got 1 expected 0 at cycle %0d", k, cyc);
        end else begin
          me = iq[k].pop_front();
          chk($sformatf("i_rdata[%0d]", k), i_rdata[k], me.rdata);
          chk($sformatf("i_fault[%0d]", k), 32'(i_fault[k]), 32'(me.fault));
          chk($sformatf("i_latency[%0d]", k), cyc, me.cyc);
        end
      end
      if (d_ready[k]) begin
        if (dq[k].size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL d_ready_unexpected[%0d]: got 1 expected 0 at cycle %0d", k, cyc);
        end else begin
          me = dq[k].pop_front();
          chk($sformatf("d_rdata[%0d]", k), d_rdata[k], me.rdata);
          chk($sformatf("d_fault[%0d]", k), 32'(d_fault[k]), 32'(me.fault));
          chk($sformatf("d_latency[%0d]", k), cyc, me.cyc);
        end
      end
    end
  end

  task automatic issue(input int k, input bit di, input logic [31:0] ia, input bit dd,
                       input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    exp_t e;
    int ws, t;
    ws = (k == 1) ? 3 : 0;
    @(negedge clk);
    if (di) begin
      model_fetch(ia, e.rdata, e.fault);
      e.cyc = cyc + 1 + ws;
      iq[k].push_back(e);
      i_req[k] = 1'b1; i_addr[k] = ia;
    end
    if (dd) begin
      model_data(k, we, f3, a, wd, e.rdata, e.fault);
      e.cyc = cyc + 1 + ws;
      dq[k].push_back(e);
      d_req[k] = 1'b1; d_we[k] = we; d_funct3[k] = f3; d_addr[k] = a; d_wdata[k] = wd;
    end
    @(negedge clk);
    i_req[k] = 1'b0; d_req[k] = 1'b0;
    t = 0;
    while (t < 20 && (iq[k].size() != 0 || dq[k].size() != 0)) begin
      @(posedge clk);
      t++;
    end
    chk($sformatf("drain_timeout[%0d]", k), iq[k].size() + dq[k].size(), 0);
    iq[k].delete(); dq[k].delete();
    @(negedge clk);
    chk($sformatf("gpio[%0d]", k), 32'(gpio[k]), 32'(gpio_m[k]));
  endtask

  task automatic fetch(input int k, input logic [31:0] a);
    issue(k, 1'b1, a, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
  endtask
  task automatic dstore(input int k, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    issue(k, 1'b0, 32'd0, 1'b1, 1'b1, f3, a, wd);
  endtask
  task automatic dload(input int k, input logic [2:0] f3, input logic [31:0] a);
    issue(k, 1'b0, 32'd0, 1'b1, 1'b0, f3, a, 32'd0);
  endtask

  task automatic chk_idle_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s_i_rdata[%0d]", tag, k), i_rdata[k], 32'd0);
      chk($sformatf("%s_d_rdata[%0d]", tag, k), d_rdata[k], 32'd0);
      chk($sformatf("%s_gpio[%0d]", tag, k), 32'(gpio[k]), 32'd0);
      chk($sformatf("%s_flags[%0d]", tag, k),
          {28'd0, i_ready[k], i_fault[k], d_ready[k], d_fault[k]}, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_daddr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return 32'($urandom_range(0, 63));
    if (r < 9) return GPIO_A + 32'($urandom_range(0, 3));
    return 32'h0000_1000 + ($urandom % 32'h1000_0000);
  endfunction

  function automatic logic [31:0] rand_iaddr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 8) return 32'($urandom_range(0, 1023)) << 2;
    if (r < 9) return 32'($urandom_range(0, 4095));
    return 32'h0000_1000 + ($urandom % 32'h0100_0000);
  endfunction

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 0; i_addr[k] = 0; d_req[k] = 0; d_we[k] = 0;
      d_funct3[k] = 0; d_addr[k] = 0; d_wdata[k] = 0; gpio_m[k] = 0;
    end
    for (int i = 0; i < 1024; i++) rom_m[i] = $urandom;
    rom_m[3] = 32'hDEAD_BEEF;
    for (int i = 0; i < 1024; i++) begin
      dut0.rom.mem[i] = rom_m[i];
      dut3.rom.mem[i] = rom_m[i];
    end
    repeat (3) @(negedge clk);
    chk_idle_zero("reset");
    rst = 1'b0;

    for (int k = 0; k < 2; k++)
      for (int w = 0; w < 16; w++) dstore(k, F3_SW, 32'(w * 4), $urandom);

    // Directed cases, zero wait states
    fetch(0, 32'h0000_000C);
    dstore(0, F3_SW, 32'h0, 32'h8081_7F01);
    dload(0, F3_LB, 32'h0);
    dload(0, F3_LB, 32'h3);
    dload(0, F3_LHU, 32'h2);
    dload(0, F3_LH, 32'h2);
    dstore(0, F3_SW, 32'h4, 32'h1122_3344);
    dstore(0, F3_SB, 32'h5, 32'h0000_00AA);
    chk("ram_sb_merge", ram_peek(0, 1), 32'h1122_AA44);
    dstore(0, F3_SH, 32'h3, 32'h0000_BEEF);
    chk("ram_sh_misaligned", ram_peek(0, 0), 32'h8081_7F01);
    dstore(0, F3_SW, GPIO_A, 32'h0000_01A5);
    chk("gpio_sw", 32'(gpio[0]), 32'h0000_00A5);
    dload(0, F3_LW, GPIO_A);
    dload(0, F3_LW, 32'h8000_0000);
    dload(0, 3'b011, 32'h0);
    dstore(0, 3'b100, 32'h8, 32'h1);
    fetch(0, 32'h0000_0002);
    fetch(0, 32'h0000_1000);
    fetch(0, 32'h0000_0FFC);

    // Three wait states: simultaneous fetch and data complete together
    issue(1, 1'b1, 32'h0000_000C, 1'b1, 1'b0, F3_LW, 32'h4, 32'd0);
    issue(1, 1'b1, 32'h0000_0010, 1'b1, 1'b1, F3_SH, 32'h6, 32'h0000_5A5A);
    dload(1, F3_LHU, 32'h6);

    // Reset during WAIT drops the store
    @(negedge clk);
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_funct3[1] = F3_SW; d_addr[1] = 32'h8; d_wdata[1] = 32'hCAFE_F00D;
    @(negedge clk);
    d_req[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    gpio_m[0] = 0; gpio_m[1] = 0;
    #1;
    chk_idle_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_ram", ram_peek(1, 2), ram_m[1][2]);
    dload(1, F3_LW, 32'h8);
    dstore(1, F3_SB, GPIO_A + 32'h1, 32'h0000_0077);
    dload(1, F3_LBU, GPIO_A);

    // Randomized mix
    for (int n = 0; n < 200; n++) begin
      int k;
      bit di, dd, we;
      k  = $urandom_range(0, 1);
      di = ($urandom_range(0, 2) == 0);
      dd = !di || ($urandom_range(0, 1) == 1);
      we = ($urandom_range(0, 2) == 0);
      issue(k, di, rand_iaddr(), dd, we, 3'($urandom_range(0, 7)), rand_daddr(), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
